// File: rtl/cfg_addr_decoder.sv
// Config-bus responder: decodes addr[15:12] to one of NUM_SLAVES region slaves,
// forwards a single outstanding transaction and returns the slave response or an error.
module cfg_addr_decoder #(
  parameter int unsigned ADDR_WIDTH     = 16,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_SLAVES     = 13,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             req_i,
  input  logic [ADDR_WIDTH-1:0]            addr_i,
  input  logic                             wen_i,
  input  logic [DATA_WIDTH-1:0]            wdata_i,
  output logic                             gnt_o,
  output logic                             rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             err_o,
  output logic [NUM_SLAVES-1:0]            slv_req_o,
  output logic [11:0]                      slv_addr_o,
  output logic                             slv_wen_o,
  output logic [DATA_WIDTH-1:0]            slv_wdata_o,
  input  logic [NUM_SLAVES-1:0]            slv_gnt_i,
  input  logic [NUM_SLAVES-1:0]            slv_rvalid_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slv_rdata_i
);

  localparam int unsigned SEL_W = 4;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_ERR
  } state_e;

  state_e                state_q;
  logic [SEL_W-1:0]      sel_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [NUM_SLAVES-1:0] slv_req_q;
  logic [11:0]           slv_addr_q;
  logic                  slv_wen_q;
  logic [DATA_WIDTH-1:0] slv_wdata_q;
  logic                  rvalid_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [SEL_W-1:0]      addr_sel;
  logic                  addr_mapped;
  logic [NUM_SLAVES-1:0] req_onehot;
  logic                  sel_gnt;
  logic                  sel_rvalid;
  logic [DATA_WIDTH-1:0] sel_rdata;
  logic                  tmo_hit;
  logic [CNT_W-1:0]      cnt_d;
  logic                  accept;

  // Region decode of the incoming address and mux of the latched slave's inputs
  always_comb begin
    addr_sel    = addr_i[15:12];
    addr_mapped = ({1'b0, addr_sel} < 5'(NUM_SLAVES));
    req_onehot  = '0;
    sel_gnt     = 1'b0;
    sel_rvalid  = 1'b0;
    sel_rdata   = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (addr_sel == SEL_W'(k)) req_onehot[k] = 1'b1;
      if (sel_q == SEL_W'(k)) begin
        sel_gnt    = slv_gnt_i[k];
        sel_rvalid = slv_rvalid_i[k];
        sel_rdata  = slv_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    // Counter parks at its final value so a grant on the last cycle still leaves one WAIT cycle
    cnt_d   = tmo_hit ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Acceptance is held off during the response pulse so the next grant lands one cycle later
  assign accept = req_i && (state_q == ST_IDLE) && !rvalid_q;
  assign gnt_o  = accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      cnt_q       <= '0;
      slv_req_q   <= '0;
      slv_addr_q  <= '0;
      slv_wen_q   <= 1'b0;
      slv_wdata_q <= '0;
      rvalid_q    <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            sel_q       <= addr_sel;
            slv_addr_q  <= addr_i[11:0];
            slv_wen_q   <= wen_i;
            slv_wdata_q <= wdata_i;
            if (addr_mapped) begin
              state_q   <= ST_REQ;
              slv_req_q <= req_onehot;
              cnt_q     <= '0;
            end else begin
              state_q  <= ST_ERR;
              rvalid_q <= 1'b1;
              err_q    <= 1'b1;
              rdata_q  <= '0;
            end
          end
        end
        ST_REQ: begin
          cnt_q <= cnt_d;
          if (sel_gnt) begin
            slv_req_q <= '0;
            state_q   <= ST_WAIT;
          end else if (tmo_hit) begin
            slv_req_q <= '0;
            state_q   <= ST_ERR;
            rvalid_q  <= 1'b1;
            err_q     <= 1'b1;
            rdata_q   <= '0;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          if (sel_rvalid) begin
            state_q  <= ST_IDLE;
            rvalid_q <= 1'b1;
            rdata_q  <= slv_wen_q ? '0 : sel_rdata;
          end else if (tmo_hit) begin
            state_q  <= ST_ERR;
            rvalid_q <= 1'b1;
            err_q    <= 1'b1;
            rdata_q  <= '0;
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign rvalid_o    = rvalid_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign slv_req_o   = slv_req_q;
  assign slv_addr_o  = slv_addr_q;
  assign slv_wen_o   = slv_wen_q;
  assign slv_wdata_o = slv_wdata_q;

endmodule

// File: tb/tb_cfg_addr_decoder.sv
// Directed bench for cfg_addr_decoder: mapped read/write, unmapped error, timeout,
// back-to-back acceptance and mid-transaction reset.
module tb_cfg_addr_decoder;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned NS = 13;
  localparam int unsigned TO = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             req_i;
  logic [AW-1:0]    addr_i;
  logic             wen_i;
  logic [DW-1:0]    wdata_i;
  logic             gnt_o;
  logic             rvalid_o;
  logic [DW-1:0]    rdata_o;
  logic             err_o;
  logic [NS-1:0]    slv_req_o;
  logic [11:0]      slv_addr_o;
  logic             slv_wen_o;
  logic [DW-1:0]    slv_wdata_o;
  logic [NS-1:0]    slv_gnt_i;
  logic [NS-1:0]    slv_rvalid_i;
  logic [NS*DW-1:0] slv_rdata_i;

  int errors = 0;
  int checks = 0;
  int req_cycles;

  always #5 clk_i = ~clk_i;

  cfg_addr_decoder #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .NUM_SLAVES    (NS),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .addr_i      (addr_i),
    .wen_i       (wen_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .slv_req_o   (slv_req_o),
    .slv_addr_o  (slv_addr_o),
    .slv_wen_o   (slv_wen_o),
    .slv_wdata_o (slv_wdata_o),
    .slv_gnt_i   (slv_gnt_i),
    .slv_rvalid_i(slv_rvalid_i),
    .slv_rdata_i (slv_rdata_i)
  );

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge; outputs are sampled and inputs driven there
  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    req_i   = 1'b1;
    addr_i  = a;
    wen_i   = w;
    wdata_i = d;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_ni       = 1'b0;
    req_i        = 1'b0;
    addr_i       = '0;
    wen_i        = 1'b0;
    wdata_i      = '0;
    slv_gnt_i    = '0;
    slv_rvalid_i = '0;
    slv_rdata_i  = '0;
    tick();
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_rvalid", 32'(rvalid_o), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    check("rst_slv_req", 32'(slv_req_o), 32'd0);
    check("rst_slv_addr", 32'(slv_addr_o), 32'd0);
    check("rst_slv_wen", 32'(slv_wen_o), 32'd0);
    check("rst_slv_wdata", slv_wdata_o, 32'd0);
    rst_ni = 1'b1;
    tick();

    // Write to region 0, fastest slave
    issue(16'h0000, 1'b1, 32'h12345678);
    check("wr_gnt_N", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    check("wr_slv_req", 32'(slv_req_o), 32'h0001);
    check("wr_slv_addr", 32'(slv_addr_o), 32'h000);
    check("wr_slv_wen", 32'(slv_wen_o), 32'd1);
    check("wr_slv_wdata", slv_wdata_o, 32'h12345678);
    slv_gnt_i[0] = 1'b1;
    tick();
    slv_gnt_i[0]    = 1'b0;
    slv_rvalid_i[0] = 1'b1;
    slv_rdata_i[0*DW +: DW] = 32'hFFFF0000;
    check("wr_slv_req_dropped", 32'(slv_req_o), 32'd0);
    check("wr_rvalid_early", 32'(rvalid_o), 32'd0);
    tick();
    slv_rvalid_i[0] = 1'b0;
    check("wr_rvalid", 32'(rvalid_o), 32'd1);
    check("wr_err", 32'(err_o), 32'd0);
    check("wr_rdata", rdata_o, 32'd0);
    tick();
    check("wr_rvalid_pulse", 32'(rvalid_o), 32'd0);

    // Read region 2; rvalid in grant cycle and from slave 5 must be ignored
    issue(16'h2008, 1'b0, 32'h0);
    check("rd_gnt_N", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    check("rd_slv_req", 32'(slv_req_o), 32'h0004);
    check("rd_slv_addr", 32'(slv_addr_o), 32'h008);
    check("rd_slv_wen", 32'(slv_wen_o), 32'd0);
    slv_gnt_i[2]    = 1'b1;
    slv_rvalid_i[2] = 1'b1;
    slv_rdata_i[2*DW +: DW] = 32'h0BAD0BAD;
    tick();
    slv_gnt_i[2]    = 1'b0;
    slv_rvalid_i[2] = 1'b0;
    slv_rvalid_i[5] = 1'b1;
    slv_rdata_i[5*DW +: DW] = 32'hDEADBEEF;
    check("rd_gntcycle_rvalid_ignored", 32'(rvalid_o), 32'd0);
    tick();
    slv_rvalid_i[5] = 1'b0;
    check("rd_spurious_ignored", 32'(rvalid_o), 32'd0);
    slv_rvalid_i[2] = 1'b1;
    slv_rdata_i[2*DW +: DW] = 32'hCAFEF00D;
    tick();
    slv_rvalid_i[2] = 1'b0;
    check("rd_rvalid", 32'(rvalid_o), 32'd1);
    check("rd_err", 32'(err_o), 32'd0);
    check("rd_rdata", rdata_o, 32'hCAFEF00D);
    tick();
    check("rd_rdata_hold", rdata_o, 32'hCAFEF00D);

    // Unmapped region 13
    issue(16'hD004, 1'b0, 32'h0);
    check("um_gnt_N", 32'(gnt_o), 32'd1);
    check("um_slv_req_N", 32'(slv_req_o), 32'd0);
    tick();
    req_i = 1'b0;
    check("um_rvalid", 32'(rvalid_o), 32'd1);
    check("um_err", 32'(err_o), 32'd1);
    check("um_rdata", rdata_o, 32'd0);
    check("um_slv_req", 32'(slv_req_o), 32'd0);
    tick();
    check("um_rvalid_pulse", 32'(rvalid_o), 32'd0);
    check("um_slv_req_after", 32'(slv_req_o), 32'd0);

    // Timeout: slave 4 never grants
    issue(16'h4000, 1'b0, 32'h0);
    check("to_gnt_N", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (slv_req_o[4] !== 1'b1) break;
      req_cycles++;
      check("to_no_rvalid_while_req", 32'(rvalid_o), 32'd0);
      tick();
    end
    check("to_req_cycles", 32'(req_cycles), 32'd8);
    check("to_rvalid", 32'(rvalid_o), 32'd1);
    check("to_err", 32'(err_o), 32'd1);
    slv_gnt_i[4]    = 1'b1;
    slv_rvalid_i[4] = 1'b1;
    tick();
    check("to_late_rvalid", 32'(rvalid_o), 32'd0);
    check("to_late_slv_req", 32'(slv_req_o), 32'd0);
    slv_gnt_i[4]    = 1'b0;
    slv_rvalid_i[4] = 1'b0;
    tick();
    check("to_late_rvalid2", 32'(rvalid_o), 32'd0);

    // Back-to-back: read 0x5000 then write 0xC004 with req_i held
    issue(16'h5000, 1'b0, 32'h0);
    check("bb1_gnt_N", 32'(gnt_o), 32'd1);
    tick();
    issue(16'hC004, 1'b1, 32'hA5A5A5A5);
    check("bb_busy_gnt", 32'(gnt_o), 32'd0);
    check("bb1_slv_req", 32'(slv_req_o), 32'h0020);
    slv_gnt_i[5] = 1'b1;
    tick();
    slv_gnt_i[5]    = 1'b0;
    slv_rvalid_i[5] = 1'b1;
    slv_rdata_i[5*DW +: DW] = 32'h11112222;
    #1;
    check("bb_wait_gnt", 32'(gnt_o), 32'd0);
    tick();
    slv_rvalid_i[5] = 1'b0;
    #1;
    check("bb1_rvalid", 32'(rvalid_o), 32'd1);
    check("bb1_rdata", rdata_o, 32'h11112222);
    check("bb_gnt_during_rvalid", 32'(gnt_o), 32'd0);
    tick();
    #1;
    check("bb2_gnt_after_rvalid", 32'(gnt_o), 32'd1);
    check("bb2_rvalid_low", 32'(rvalid_o), 32'd0);
    tick();
    req_i = 1'b0;
    check("bb2_slv_req", 32'(slv_req_o), 32'h1000);
    check("bb2_slv_addr", 32'(slv_addr_o), 32'h004);
    check("bb2_slv_wen", 32'(slv_wen_o), 32'd1);
    check("bb2_slv_wdata", slv_wdata_o, 32'hA5A5A5A5);
    slv_gnt_i[12] = 1'b1;
    tick();
    slv_gnt_i[12]    = 1'b0;
    slv_rvalid_i[12] = 1'b1;
    slv_rdata_i[12*DW +: DW] = 32'h5555AAAA;
    tick();
    slv_rvalid_i[12] = 1'b0;
    check("bb2_rvalid", 32'(rvalid_o), 32'd1);
    check("bb2_err", 32'(err_o), 32'd0);
    check("bb2_rdata", rdata_o, 32'd0);
    tick();

    // Reset during WAIT of a read to 0x8004
    issue(16'h8004, 1'b0, 32'h0);
    tick();
    req_i = 1'b0;
    check("rs_slv_req", 32'(slv_req_o), 32'h0100);
    slv_gnt_i[8] = 1'b1;
    tick();
    slv_gnt_i[8] = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("rs_slv_req_clr", 32'(slv_req_o), 32'd0);
    check("rs_slv_addr_clr", 32'(slv_addr_o), 32'd0);
    check("rs_rvalid_clr", 32'(rvalid_o), 32'd0);
    check("rs_err_clr", 32'(err_o), 32'd0);
    tick();
    rst_ni = 1'b1;
    slv_rvalid_i[8] = 1'b1;
    slv_rdata_i[8*DW +: DW] = 32'h77777777;
    tick();
    slv_rvalid_i[8] = 1'b0;
    check("rs_no_resp1", 32'(rvalid_o), 32'd0);
    tick();
    check("rs_no_resp2", 32'(rvalid_o), 32'd0);
    issue(16'h8004, 1'b0, 32'h0);
    check("rs2_gnt_N", 32'(gnt_o), 32'd1);
    tick();
    req_i = 1'b0;
    check("rs2_slv_req", 32'(slv_req_o), 32'h0100);
    check("rs2_slv_addr", 32'(slv_addr_o), 32'h004);
    slv_gnt_i[8] = 1'b1;
    tick();
    slv_gnt_i[8]    = 1'b0;
    slv_rvalid_i[8] = 1'b1;
    slv_rdata_i[8*DW +: DW] = 32'h0BADC0DE;
    tick();
    slv_rvalid_i[8] = 1'b0;
    check("rs2_rvalid", 32'(rvalid_o), 32'd1);
    check("rs2_err", 32'(err_o), 32'd0);
    check("rs2_rdata", rdata_o, 32'h0BADC0DE);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
